// File: rtl/mem_ooo_responder.sv
// Out-of-order read responder: ID-indexed pending table with per-slot latency countdown,
// lowest-ID-first return arbitration and a backdoor-loaded backing store.
module mem_ooo_responder #(
    parameter int          N         = 16,
    parameter int          AW        = 8,
    parameter int          DW        = 8,
    parameter int          MIN_LAT   = 2,
    parameter int          LAT_MASK  = 7,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    localparam int         IW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          mem_read_req,
    input  logic [AW-1:0] mem_read_addr,
    input  logic [IW-1:0] mem_req_id,
    output logic          mem_rd_vld,
    output logic [IW-1:0] mem_resp_id,
    output logic [DW-1:0] mem_rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          cfg_fixed_lat,
    output logic [IW:0]   outstanding,
    output logic          err_dup
);

    localparam int CW = $clog2(MIN_LAT + LAT_MASK + 1);

    logic [DW-1:0] store     [2**AW];
    logic [DW-1:0] slot_data [N];
    logic [CW-1:0] slot_cnt  [N];
    logic [N-1:0]  pending;
    logic [N-1:0]  eligible;
    logic [7:0]    lfsr;
    logic [7:0]    lat_add;
    logic [CW-1:0] lat_m1;
    logic          win_vld;
    logic [IW-1:0] win_id;
    logic          accept;
    logic          dup;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = pending[i] && (slot_cnt[i] == '0);
        end
    end

    // Descending scan so the lowest eligible ID is the last to assign.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_id  = IW'(i);
            end
        end
    end

    // The retiring slot may be re-filled on the same edge it returns.
    assign accept  = mem_read_req &&
                     (!pending[mem_req_id] || (win_vld && (win_id == mem_req_id)));
    assign dup     = mem_read_req && !accept;
    assign lat_add = cfg_fixed_lat ? 8'd0 : (lfsr & 8'(LAT_MASK));
    assign lat_m1  = CW'(MIN_LAT - 1) + CW'(lat_add);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_addr] <= wr_data;
        end
    end

    // Old store contents are captured when a backdoor write hits the same address.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_data[mem_req_id] <= store[mem_read_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending     <= '0;
            lfsr        <= LFSR_SEED;
            mem_rd_vld  <= 1'b0;
            mem_resp_id <= '0;
            mem_rd_data <= '0;
            outstanding <= '0;
            err_dup     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                slot_cnt[i] <= '0;
            end
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            for (int i = 0; i < N; i++) begin
                if (accept && (mem_req_id == IW'(i))) begin
                    pending[i]  <= 1'b1;
                    slot_cnt[i] <= lat_m1;
                end else if (win_vld && (win_id == IW'(i))) begin
                    pending[i]  <= 1'b0;
                end else if (pending[i] && (slot_cnt[i] != '0)) begin
                    slot_cnt[i] <= slot_cnt[i] - CW'(1);
                end
            end
            mem_rd_vld <= win_vld;
            if (win_vld) begin
                mem_resp_id <= win_id;
                mem_rd_data <= slot_data[win_id];
            end
            case ({accept, win_vld})
                2'b10:   outstanding <= outstanding + (IW+1)'(1);
                2'b01:   outstanding <= outstanding - (IW+1)'(1);
                default: outstanding <= outstanding;
            endcase
            err_dup <= err_dup | dup;
        end
    end

endmodule

// File: tb/tb_mem_ooo_responder.sv
// Bench for mem_ooo_responder: absolute-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_ooo_responder;

    localparam int         N        = 16;
    localparam int         AW       = 8;
    localparam int         DW       = 8;
    localparam int         MIN_LAT  = 2;
    localparam int         LAT_MASK = 7;
    localparam int         IW       = 4;
    localparam logic [7:0] SEED     = 8'hA5;

    logic          clk;
    logic          rstn;
    logic          mem_read_req;
    logic [AW-1:0] mem_read_addr;
    logic [IW-1:0] mem_req_id;
    logic          mem_rd_vld;
    logic [IW-1:0] mem_resp_id;
    logic [DW-1:0] mem_rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cfg_fixed_lat;
    logic [IW:0]   outstanding;
    logic          err_dup;

    mem_ooo_responder #(
        .N(N), .AW(AW), .DW(DW), .MIN_LAT(MIN_LAT), .LAT_MASK(LAT_MASK), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rstn(rstn),
        .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr), .mem_req_id(mem_req_id),
        .mem_rd_vld(mem_rd_vld), .mem_resp_id(mem_resp_id), .mem_rd_data(mem_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_fixed_lat(cfg_fixed_lat), .outstanding(outstanding), .err_dup(err_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each slot remembers the absolute edge at which it may win.
    bit         m_pend  [N];
    int         m_ready [N];
    logic [7:0] m_data  [N];
    logic [7:0] m_store [256];
    logic [7:0] m_lfsr;
    int         edge_no = 0;
    logic       e_vld = 1'b0;
    int         e_id = 0;
    logic [7:0] e_data = 8'h00;
    int         e_out = 0;
    logic       e_err = 1'b0;

    always @(posedge clk) begin
        int  w;
        bit  found;
        int  cnt;
        if (!rstn) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_lfsr = SEED;
            e_vld  = 1'b0;
            e_id   = 0;
            e_data = 8'h00;
            e_out  = 0;
            e_err  = 1'b0;
        end else begin
            found = 1'b0;
            w     = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && m_pend[i] && (m_ready[i] <= edge_no)) begin
                    found = 1'b1;
                    w     = i;
                end
            end
            e_vld = found;
            if (found) begin
                e_id      = w;
                e_data    = m_data[w];
                m_pend[w] = 1'b0;
            end
            if (mem_read_req) begin
                if (m_pend[mem_req_id]) begin
                    e_err = 1'b1;
                end else begin
                    m_pend[mem_req_id]  = 1'b1;
                    m_ready[mem_req_id] = edge_no + MIN_LAT +
                                          (cfg_fixed_lat ? 0 : int'(m_lfsr) % (LAT_MASK + 1));
                    m_data[mem_req_id]  = m_store[mem_read_addr];
                end
            end
            cnt = 0;
            for (int i = 0; i < N; i++) cnt += int'(m_pend[i]);
            e_out  = cnt;
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        if (wr_en) m_store[wr_addr] = wr_data;
        edge_no++;
    end

    int vectors = 0;
    int miscompares = 0;
    int resp_seen [N];
    int base_seen [N];
    int pk_d = 0;
    int pk_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
        end
    endtask

    // Advance one cycle and compare the DUT against the model on the falling edge.
    task automatic step();
        @(negedge clk);
        chk("cyc_rd_vld", 32'(mem_rd_vld), 32'(e_vld));
        if (e_vld === 1'b1) begin
            chk("cyc_resp_id", 32'(mem_resp_id), 32'(e_id));
            chk("cyc_rd_data", 32'(mem_rd_data), 32'(e_data));
        end
        chk("cyc_outstanding", 32'(outstanding), 32'(e_out));
        chk("cyc_err_dup", 32'(err_dup), 32'(e_err));
        if (mem_rd_vld === 1'b1) resp_seen[mem_resp_id]++;
        if (int'(outstanding) > pk_d) pk_d = int'(outstanding);
        if (e_out > pk_m) pk_m = e_out;
    endtask

    task automatic idle();
        mem_read_req = 1'b0;
        wr_en        = 1'b0;
    endtask

    task automatic req(input int id, input int addr);
        mem_read_req  = 1'b1;
        mem_req_id    = IW'(id);
        mem_read_addr = AW'(addr);
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        step();
        chk("rst_vld", 32'(mem_rd_vld), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err_dup), 0);
        rstn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) resp_seen[i] = 0;
        rstn = 1'b0; mem_read_req = 1'b0; mem_read_addr = '0; mem_req_id = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; cfg_fixed_lat = 1'b1;

        // Preload: store[a] = a ^ 0x5A, then the two directed values.
        for (int a = 0; a < 256; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a ^ 'h5A);
            step();
        end
        wr_addr = 8'h10; wr_data = 8'h3C; step();
        wr_addr = 8'h20; wr_data = 8'h11; step();
        idle();

        // Fixed-latency single read
        cfg_fixed_lat = 1'b1;
        do_reset();
        req(5, 'h10); step(); idle();
        chk("fix_vld_e0", 32'(mem_rd_vld), 0);
        chk("fix_out_e0", 32'(outstanding), 1);
        step(); chk("fix_vld_e1", 32'(mem_rd_vld), 0);
        step();
        chk("fix_vld_e2", 32'(mem_rd_vld), 1);
        chk("fix_id_e2", 32'(mem_resp_id), 5);
        chk("fix_data_e2", 32'(mem_rd_data), 'h3C);
        step();
        chk("fix_vld_e3", 32'(mem_rd_vld), 0);
        chk("fix_out_e3", 32'(outstanding), 0);

        // Staggered eligibility: no reorder
        req(3, 'h03); step(); req(1, 'h01); step(); req(2, 'h02); step(); idle();
        chk("stag_first", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h13);
        step(); chk("stag_second", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h11);
        step(); chk("stag_third", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h12);
        step(); chk("stag_done", 32'(mem_rd_vld), 0);

        // Wrap-around IDs 15 then 0
        req(15, 'h0F); step(); req(0, 'h00); step(); idle();
        step(); chk("wrap_id15", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h1F);
        step(); chk("wrap_id0", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h10);

        // Simultaneous eligibility: LFSR A5,4A,95,2A -> latencies 7,4,7,4
        cfg_fixed_lat = 1'b0;
        do_reset();
        req(9, 'h09); step(); idle(); step(); step();
        req(6, 'h06); step(); idle();
        step(); step(); step();
        chk("tie_none_yet", 32'(mem_rd_vld), 0);
        step();
        chk("tie_low_first", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h16);
        chk("tie_low_data", 32'(mem_rd_data), 'h06 ^ 'h5A);
        step();
        chk("tie_high_next", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h19);
        chk("tie_high_data", 32'(mem_rd_data), 'h09 ^ 'h5A);
        step(); chk("tie_done", 32'(mem_rd_vld), 0);

        // Duplicate request
        cfg_fixed_lat = 1'b1;
        do_reset();
        req(7, 'h30); step(); chk("dup_err_before", 32'(err_dup), 0);
        req(7, 'h31); step(); idle(); chk("dup_err_set", 32'(err_dup), 1);
        step();
        chk("dup_resp", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h17);
        chk("dup_data", 32'(mem_rd_data), 'h30 ^ 'h5A);
        step(); chk("dup_no_second", 32'(mem_rd_vld), 0);
        step(); chk("dup_err_sticky", 32'(err_dup), 1);

        // Same-cycle reuse of the retiring ID
        do_reset();
        req(7, 'h40); step(); idle(); step();
        req(7, 'h41); step(); idle();
        chk("reuse_first", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h17);
        chk("reuse_first_data", 32'(mem_rd_data), 'h40 ^ 'h5A);
        step(); chk("reuse_gap", 32'(mem_rd_vld), 0);
        step();
        chk("reuse_second", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h17);
        chk("reuse_second_data", 32'(mem_rd_data), 'h41 ^ 'h5A);
        chk("reuse_no_err", 32'(err_dup), 0);

        // Read-before-write on the same edge
        req(2, 'h20); wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h22; step(); idle();
        step(); step();
        chk("rbw_old", 32'(mem_rd_data), 'h11);
        req(3, 'h20); step(); idle(); step(); step();
        chk("rbw_new", 32'(mem_rd_data), 'h22);

        // Random out-of-order: 16 IDs back-to-back
        cfg_fixed_lat = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++) base_seen[i] = resp_seen[i];
        pk_d = 0; pk_m = 0;
        for (int i = 0; i < N; i++) begin
            req(i, 'h50 + 3 * i); step();
        end
        idle();
        for (int i = 0; i < 40; i++) step();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ooo_once_id%0d", i), 32'(resp_seen[i] - base_seen[i]), 1);
        end
        chk("ooo_peak", 32'(pk_d), 32'(pk_m));
        chk("ooo_drained", 32'(outstanding), 0);

        // Reset mid-flight: latencies 7,4,7,4 keep all four pending through edge R+5
        do_reset();
        req(0, 'h60); step(); req(1, 'h61); step(); req(2, 'h62); step(); req(3, 'h63); step();
        chk("mid_out4", 32'(outstanding), 4);
        req(0, 'h64); step(); idle();
        chk("mid_err", 32'(err_dup), 1);
        chk("mid_out_still4", 32'(outstanding), 4);
        cfg_fixed_lat = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            chk("mid_no_resp", 32'(mem_rd_vld), 0);
        end
        req(4, 'h10); step(); idle(); step(); step();
        chk("mid_after_id", 32'({mem_rd_vld, 4'(mem_resp_id)}), 'h14);
        chk("mid_store_kept", 32'(mem_rd_data), 'h3C);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
